// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared timing constants and the per-axis timing description used by
// video_timing_gen and video_axis_decode.
//   timing_axis_t : {active, fp, sync, bp} in dots (horizontal) or lines (vertical)
//   NES_*         : NES NTSC raster, 341 x 262, vblank flag raised at dot 1 of line 241
//   VGA_*         : 640x480 @ 60 Hz raster, 800 x 525
//   axis_total()  : full period of one axis

package video_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_axis_t;

    localparam timing_axis_t NES_H_AXIS = '{active: 256, fp: 24, sync: 25, bp: 36};
    localparam timing_axis_t NES_V_AXIS = '{active: 240, fp: 3,  sync: 3,  bp: 16};
    localparam int unsigned  NES_VBL_LINE = 241;
    localparam int unsigned  NES_VBL_DOT  = 1;

    localparam timing_axis_t VGA_H_AXIS = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam timing_axis_t VGA_V_AXIS = '{active: 480, fp: 10, sync: 2,  bp: 33};

    function automatic int unsigned axis_total(timing_axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if
// Bundles the pixel-enable inputs and the raster outputs of video_timing_gen.
//   master : the timing generator (drives coordinates, syncs, strobes)
//   slave  : the consumer (PPU renderer / VGA stage), drives PixEn and RenderEn
//   PixEn, RenderEn      : pixel clock-enable, rendering-enabled flag
//   hs, vs, sync, blank  : sync levels, composite sync, active-region flag
//   DrawX, DrawY         : current dot / line (CW bits)
//   line_start, frame_start, vblank_start : one-enabled-cycle event strobes
//   odd_frame            : parity of the current frame

interface video_timing_gen_if #(
    parameter int unsigned CW = 11
);
    logic          PixEn;
    logic          RenderEn;
    logic          hs;
    logic          vs;
    logic          blank;
    logic          sync;
    logic [CW-1:0] DrawX;
    logic [CW-1:0] DrawY;
    logic          line_start;
    logic          frame_start;
    logic          vblank_start;
    logic          odd_frame;

    modport master (
        input  PixEn, RenderEn,
        output hs, vs, blank, sync, DrawX, DrawY,
               line_start, frame_start, vblank_start, odd_frame
    );

    modport slave (
        output PixEn, RenderEn,
        input  hs, vs, blank, sync, DrawX, DrawY,
               line_start, frame_start, vblank_start, odd_frame
    );
endinterface

// File: rtl/video_axis_decode.sv
// video_axis_decode
// Decodes one raster axis position into its active flag and sync level.
//   pos      : dot or line position (CW bits)
//   active   : 1 while pos < AXIS.active
//   sync_lvl : POL inside [active+fp, active+fp+sync), ~POL elsewhere

module video_axis_decode
    import video_timing_pkg::*;
#(
    parameter int unsigned  CW   = 11,
    parameter timing_axis_t AXIS = NES_H_AXIS,
    parameter bit           POL  = 1'b0
) (
    input  logic [CW-1:0] pos,
    output logic          active,
    output logic          sync_lvl
);

    localparam int unsigned SYNC_LO = AXIS.active + AXIS.fp;
    localparam int unsigned SYNC_HI = SYNC_LO + AXIS.sync;

    // Widen once so every compare is unsigned at 32 bits, no truncation of
    // constants that land exactly on 2**CW.
    logic [31:0] pos_w;
    logic        in_sync;

    assign pos_w    = 32'(pos);
    assign active   = (pos_w < AXIS.active);
    assign in_sync  = (pos_w >= SYNC_LO) && (pos_w < SYNC_HI);
    assign sync_lvl = in_sync ? POL : ~POL;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Raster timing generator: dot/line counters advanced by PixEn, with
// registered hs/vs/blank and event strobes aligned to DrawX/DrawY, plus the
// NES odd-frame dot skip.
//   Clk, Reset_n : system clock, synchronous active-low reset
//   vt (master)  : PixEn/RenderEn in; hs, vs, blank, sync, DrawX, DrawY,
//                  line_start, frame_start, vblank_start, odd_frame out

module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned CW       = 11,
    parameter int unsigned H_ACTIVE = NES_H_AXIS.active,
    parameter int unsigned H_FP     = NES_H_AXIS.fp,
    parameter int unsigned H_SYNC   = NES_H_AXIS.sync,
    parameter int unsigned H_BP     = NES_H_AXIS.bp,
    parameter int unsigned V_ACTIVE = NES_V_AXIS.active,
    parameter int unsigned V_FP     = NES_V_AXIS.fp,
    parameter int unsigned V_SYNC   = NES_V_AXIS.sync,
    parameter int unsigned V_BP     = NES_V_AXIS.bp,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter bit          SKIP_DOT = 1'b1,
    parameter int unsigned VBL_LINE = NES_VBL_LINE,
    parameter int unsigned VBL_DOT  = NES_VBL_DOT
) (
    input  logic               Clk,
    input  logic               Reset_n,
    video_timing_gen_if.master vt
);

    localparam timing_axis_t H_AXIS  = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_axis_t V_AXIS  = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int unsigned  H_TOTAL = axis_total(H_AXIS);
    localparam int unsigned  V_TOTAL = axis_total(V_AXIS);

    if (H_TOTAL > (2 ** CW)) begin : g_h_total_err
        $error("video_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (2 ** CW)) begin : g_v_total_err
        $error("video_timing_gen: V_TOTAL does not fit in CW bits");
    end
    if (VBL_LINE >= V_TOTAL) begin : g_vbl_line_err
        $error("video_timing_gen: VBL_LINE must be below V_TOTAL");
    end
    if (VBL_DOT >= H_TOTAL) begin : g_vbl_dot_err
        $error("video_timing_gen: VBL_DOT must be below H_TOTAL");
    end

    logic [CW-1:0] x_q, y_q;
    logic [CW-1:0] x_nx, y_nx;
    logic          odd_q;
    logic          hs_q, vs_q, blank_q;
    logic          ls_q, fs_q, vbs_q;
    logic          at_eol, at_last_line, skip;
    logic          h_act_nx, v_act_nx, hs_nx, vs_nx;
    logic          origin_nx;

    assign at_eol       = (32'(x_q) == H_TOTAL - 1);
    assign at_last_line = (32'(y_q) == V_TOTAL - 1);

    // Odd-frame short line: the last dot of the pre-render line is dropped
    // and the counter jumps straight to (0,0).
    assign skip = SKIP_DOT && odd_q && vt.RenderEn && at_last_line
                  && (32'(x_q) == H_TOTAL - 2);

    always_comb begin
        x_nx = x_q + CW'(1);
        y_nx = y_q;
        if (skip || at_eol) begin
            x_nx = '0;
            y_nx = at_last_line ? '0 : y_q + CW'(1);
        end
    end

    assign origin_nx = (x_nx == '0) && (y_nx == '0);

    // Decode the next position so the registered levels line up with the
    // registered coordinates.
    video_axis_decode #(.CW(CW), .AXIS(H_AXIS), .POL(HS_POL)) u_h_decode (
        .pos      (x_nx),
        .active   (h_act_nx),
        .sync_lvl (hs_nx)
    );

    video_axis_decode #(.CW(CW), .AXIS(V_AXIS), .POL(VS_POL)) u_v_decode (
        .pos      (y_nx),
        .active   (v_act_nx),
        .sync_lvl (vs_nx)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            x_q     <= '0;
            y_q     <= CW'(V_TOTAL - 1);
            odd_q   <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            vbs_q   <= 1'b0;
        end else if (vt.PixEn) begin
            x_q     <= x_nx;
            y_q     <= y_nx;
            hs_q    <= hs_nx;
            vs_q    <= vs_nx;
            blank_q <= h_act_nx & v_act_nx;
            ls_q    <= (x_nx == '0);
            fs_q    <= origin_nx;
            vbs_q   <= (32'(x_nx) == VBL_DOT) && (32'(y_nx) == VBL_LINE);
            if (origin_nx) begin
                odd_q <= ~odd_q;
            end
        end else begin
            // Strobes must not stretch across disabled cycles.
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
            vbs_q <= 1'b0;
        end
    end

    assign vt.DrawX        = x_q;
    assign vt.DrawY        = y_q;
    assign vt.hs           = hs_q;
    assign vt.vs           = vs_q;
    assign vt.blank        = blank_q;
    assign vt.line_start   = ls_q;
    assign vt.frame_start  = fs_q;
    assign vt.vblank_start = vbs_q;
    assign vt.odd_frame    = odd_q;
    assign vt.sync         = 1'b0;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
// Directed bench for video_timing_gen. One instance uses the NES defaults;
// two use a 15 x 8 raster (H 8/2/3/2, V 4/1/2/1, hs low on dots 10..12,
// vs high on lines 5..6, vblank at line 5) so whole frames stay short:
//   u_sm : SKIP_DOT=1, VBL_DOT=1
//   u_z  : SKIP_DOT=0, VBL_DOT=0

module tb_video_timing_gen;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic pix_en = 1'b1;
    logic render_en = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always #5 Clk = ~Clk;

    video_timing_gen_if #(.CW(11)) if_nes ();
    video_timing_gen_if #(.CW(5))  if_sm ();
    video_timing_gen_if #(.CW(5))  if_z ();

    assign if_nes.PixEn    = pix_en;
    assign if_nes.RenderEn = render_en;
    assign if_sm.PixEn     = pix_en;
    assign if_sm.RenderEn  = render_en;
    assign if_z.PixEn      = pix_en;
    assign if_z.RenderEn   = render_en;

    video_timing_gen u_nes (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .vt      (if_nes)
    );

    video_timing_gen #(
        .CW(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .SKIP_DOT(1'b1),
        .VBL_LINE(5), .VBL_DOT(1)
    ) u_sm (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .vt      (if_sm)
    );

    video_timing_gen #(
        .CW(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .SKIP_DOT(1'b0),
        .VBL_LINE(5), .VBL_DOT(0)
    ) u_z (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .vt      (if_z)
    );

    // {DrawX, DrawY, hs, vs, blank, line_start, frame_start, vblank_start, odd_frame}
    logic [16:0] sm_obs, z_obs;
    assign sm_obs = {if_sm.DrawX, if_sm.DrawY, if_sm.hs, if_sm.vs, if_sm.blank,
                     if_sm.line_start, if_sm.frame_start, if_sm.vblank_start, if_sm.odd_frame};
    assign z_obs  = {if_z.DrawX, if_z.DrawY, if_z.hs, if_z.vs, if_z.blank,
                     if_z.line_start, if_z.frame_start, if_z.vblank_start, if_z.odd_frame};

    function automatic logic [16:0] exp_vec(input int x, input int y, input bit odd,
                                            input int vbl_dot);
        logic hs_e, vs_e, bl_e, ls_e, fs_e, vb_e;
        hs_e = (x >= 10 && x < 13) ? 1'b0 : 1'b1;
        vs_e = (y >= 5 && y < 7) ? 1'b1 : 1'b0;
        bl_e = (x < 8 && y < 4) ? 1'b1 : 1'b0;
        ls_e = (x == 0) ? 1'b1 : 1'b0;
        fs_e = (x == 0 && y == 0) ? 1'b1 : 1'b0;
        vb_e = (x == vbl_dot && y == 5) ? 1'b1 : 1'b0;
        return {5'(x), 5'(y), hs_e, vs_e, bl_e, ls_e, fs_e, vb_e, odd};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        pix_en  = 1'b1;
        repeat (3) step();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int n, hs_lo, first_lo, sm_fs_at;
        render_en = 1'b0;
        do_reset();
        tests++;
        if ({if_nes.DrawX, if_nes.DrawY} !== {11'd0, 11'd261}) begin
            fails++;
            $display("FAIL reset_pos got (%0d,%0d) want (0,261)", if_nes.DrawX, if_nes.DrawY);
        end
        tests++;
        if ({if_nes.hs, if_nes.vs, if_nes.blank, if_nes.sync} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_levels got %b want 1100",
                     {if_nes.hs, if_nes.vs, if_nes.blank, if_nes.sync});
        end
        tests++;
        if ({if_nes.line_start, if_nes.frame_start, if_nes.vblank_start, if_nes.odd_frame} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_strobes got %b want 0000",
                     {if_nes.line_start, if_nes.frame_start, if_nes.vblank_start, if_nes.odd_frame});
        end
        tests++;
        if (sm_obs !== {5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0}) begin
            fails++;
            $display("FAIL reset_small got %h want %h", sm_obs, {5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0});
        end
        n = 0; hs_lo = 0; first_lo = -1; sm_fs_at = -1;
        while (n < 400) begin
            step();
            n++;
            if (if_nes.frame_start) break;
            if (if_nes.hs == 1'b0) begin
                hs_lo++;
                if (first_lo < 0) first_lo = int'(if_nes.DrawX);
            end
            if (if_sm.frame_start && sm_fs_at < 0) sm_fs_at = n;
        end
        tests++;
        if (n !== 341) begin
            fails++;
            $display("FAIL nes_first_frame_start got %0d want 341", n);
        end
        tests++;
        if (hs_lo !== 25) begin
            fails++;
            $display("FAIL nes_hs_width got %0d want 25", hs_lo);
        end
        tests++;
        if (first_lo !== 280) begin
            fails++;
            $display("FAIL nes_hs_first_dot got %0d want 280", first_lo);
        end
        tests++;
        if (sm_fs_at !== 15) begin
            fails++;
            $display("FAIL sm_first_frame_start got %0d want 15", sm_fs_at);
        end
    endtask

    // Full-frame walk on the small raster; with render set, odd frames end at dot 13.
    task automatic run_frames(input int nframes, input bit render, input bit chk_z);
        int fs_last, prev_len, xmax, blank_cnt, flen;
        bit eodd;
        render_en = render;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            step();
            tests++;
            if (sm_obs !== exp_vec(k, 7, 1'b0, 1)) begin
                fails++;
                $display("FAIL sm_preline k=%0d got %h want %h", k, sm_obs, exp_vec(k, 7, 1'b0, 1));
            end
        end
        fs_last = -1; prev_len = 0; eodd = 1'b0;
        for (int f = 0; f < nframes; f++) begin
            eodd = ~eodd;
            blank_cnt = 0;
            flen = 0;
            for (int y = 0; y < 8; y++) begin
                xmax = (render && eodd && y == 7) ? 13 : 14;
                for (int x = 0; x <= xmax; x++) begin
                    step();
                    flen++;
                    tests++;
                    if (sm_obs !== exp_vec(x, y, eodd, 1)) begin
                        fails++;
                        $display("FAIL sm_scan f=%0d (%0d,%0d) got %h want %h",
                                 f, x, y, sm_obs, exp_vec(x, y, eodd, 1));
                    end
                    if (chk_z) begin
                        tests++;
                        if (z_obs !== exp_vec(x, y, eodd, 0)) begin
                            fails++;
                            $display("FAIL z_scan f=%0d (%0d,%0d) got %h want %h",
                                     f, x, y, z_obs, exp_vec(x, y, eodd, 0));
                        end
                    end
                    if (if_sm.blank) blank_cnt++;
                    if (if_sm.frame_start) begin
                        if (fs_last >= 0) begin
                            tests++;
                            if (cyc - fs_last !== prev_len) begin
                                fails++;
                                $display("FAIL sm_frame_period got %0d want %0d", cyc - fs_last, prev_len);
                            end
                        end
                        fs_last = cyc;
                    end
                end
            end
            tests++;
            if (blank_cnt !== 32) begin
                fails++;
                $display("FAIL sm_blank_count f=%0d got %0d want 32", f, blank_cnt);
            end
            prev_len = flen;
        end
        step();
        tests++;
        if (sm_obs !== exp_vec(0, 0, ~eodd, 1)) begin
            fails++;
            $display("FAIL sm_frame_wrap got %h want %h", sm_obs, exp_vec(0, 0, ~eodd, 1));
        end
        tests++;
        if (cyc - fs_last !== prev_len) begin
            fails++;
            $display("FAIL sm_last_period got %0d want %0d", cyc - fs_last, prev_len);
        end
    endtask

    task automatic test_scan_no_skip();
        run_frames(2, 1'b0, 1'b1);
    endtask

    task automatic test_dot_skip();
        run_frames(3, 1'b1, 1'b0);
    endtask

    task automatic test_pixen_toggle();
        logic [13:0] snap, cur;
        int fs_cnt, first, period;
        bit en, prev_fs;
        render_en = 1'b0;
        do_reset();
        fs_cnt = 0; first = -1; period = -1; prev_fs = 1'b0;
        for (int i = 0; i < 600 && fs_cnt < 2; i++) begin
            en = (i % 2 == 0);
            pix_en = en;
            snap = {if_sm.DrawX, if_sm.DrawY, if_sm.hs, if_sm.vs, if_sm.blank, if_sm.odd_frame};
            step();
            cur = {if_sm.DrawX, if_sm.DrawY, if_sm.hs, if_sm.vs, if_sm.blank, if_sm.odd_frame};
            if (!en) begin
                tests++;
                if (cur !== snap) begin
                    fails++;
                    $display("FAIL pixen_hold i=%0d got %h want %h", i, cur, snap);
                end
                tests++;
                if ({if_sm.line_start, if_sm.frame_start, if_sm.vblank_start} !== 3'b000) begin
                    fails++;
                    $display("FAIL pixen_strobe_low i=%0d got %b want 000", i,
                             {if_sm.line_start, if_sm.frame_start, if_sm.vblank_start});
                end
            end
            if (if_sm.frame_start) begin
                tests++;
                if (prev_fs !== 1'b0) begin
                    fails++;
                    $display("FAIL pixen_fs_width i=%0d got 2+ cycles want 1", i);
                end
                fs_cnt++;
                if (fs_cnt == 1) first = i;
                else period = i - first;
            end
            prev_fs = if_sm.frame_start;
        end
        pix_en = 1'b1;
        tests++;
        if (first !== 28) begin
            fails++;
            $display("FAIL pixen_first_fs got %0d want 28", first);
        end
        tests++;
        if (period !== 240) begin
            fails++;
            $display("FAIL pixen_period got %0d want 240", period);
        end
    endtask

    task automatic test_mid_reset();
        int n, start;
        render_en = 1'b1;
        do_reset();
        repeat (50) step();
        tests++;
        if (sm_obs !== exp_vec(5, 2, 1'b1, 1)) begin
            fails++;
            $display("FAIL mid_pre_reset got %h want %h", sm_obs, exp_vec(5, 2, 1'b1, 1));
        end
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        tests++;
        if (sm_obs !== {5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset_state got %h want %h", sm_obs, {5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0});
        end
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (if_sm.frame_start) break;
        end
        tests++;
        if (n !== 15) begin
            fails++;
            $display("FAIL mid_first_fs got %0d want 15", n);
        end
        start = cyc;
        n = 0;
        while (n < 300) begin
            step();
            n++;
            if (if_sm.frame_start) break;
        end
        tests++;
        if (cyc - start !== 119) begin
            fails++;
            $display("FAIL mid_odd_period got %0d want 119", cyc - start);
        end
    endtask

    initial begin
        test_reset();
        test_scan_no_skip();
        test_dot_skip();
        test_pixen_toggle();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
